// File: rtl/matmul_tile_sequencer_pkg.sv
// Shared definitions for the 2x2-block matrix-multiply sequencer: state encoding,
// operand/result select constants and the P/Q/R memory base offsets.
package matmul_tile_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCompute,
        StStore,
        StDone
    } state_e;

    localparam logic [2:0] OP_A = 3'd0;
    localparam logic [2:0] OP_B = 3'd1;
    localparam logic [2:0] OP_C = 3'd2;
    localparam logic [2:0] OP_D = 3'd3;
    localparam logic [2:0] OP_E = 3'd4;
    localparam logic [2:0] OP_F = 3'd5;
    localparam logic [2:0] OP_G = 3'd6;
    localparam logic [2:0] OP_H = 3'd7;

    localparam logic [1:0] SEL_J = 2'd0;
    localparam logic [1:0] SEL_K = 2'd1;
    localparam logic [1:0] SEL_L = 2'd2;
    localparam logic [1:0] SEL_M = 2'd3;

    function automatic logic [31:0] p_base();
        return 32'd0;
    endfunction

    function automatic logic [31:0] q_base(input int unsigned n);
        return n * n;
    endfunction

    function automatic logic [31:0] r_base(input int unsigned n);
        return 2 * n * n;
    endfunction

endpackage

// File: rtl/matmul_addr_gen.sv
// Combinational operand-read and result-write address generation for one
// (bi, bj, bk) block; addresses are row-major and wrap modulo 2^ADDR_W.
module matmul_addr_gen
    import matmul_tile_sequencer_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned TW     = 1
) (
    input  logic [TW-1:0]     bi,
    input  logic [TW-1:0]     bj,
    input  logic [TW-1:0]     bk,
    input  logic [2:0]        op,
    input  logic [1:0]        s,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr
);

    logic [31:0] rd_row;
    logic [31:0] rd_col;
    logic [31:0] rd_full;
    logic [31:0] wr_full;

    always_comb begin
        // op[2] picks the Q operand block (rows from bk, cols from bj) over P (rows bi, cols bk)
        rd_row  = op[2] ? (2 * 32'(bk) + 32'(op[1])) : (2 * 32'(bi) + 32'(op[1]));
        rd_col  = op[2] ? (2 * 32'(bj) + 32'(op[0])) : (2 * 32'(bk) + 32'(op[0]));
        rd_full = (op[2] ? q_base(N) : p_base()) + rd_row * N + rd_col;
        wr_full = r_base(N) + (2 * 32'(bi) + 32'(s[1])) * N + 2 * 32'(bj) + 32'(s[0]);
        rd_addr = rd_full[ADDR_W-1:0];
        wr_addr = wr_full[ADDR_W-1:0];
    end

endmodule

// File: rtl/matmul_tile_sequencer.sv
// Tile sequencer for the 2x2-block matrix multiply: walks (bi, bj, bk), loads operands
// A..H, pulses accumulate and stores J..M. Define SEQ_STALL_COUNT_EN for stall_count.
module matmul_tile_sequencer
    import matmul_tile_sequencer_pkg::*;
#(
    parameter int unsigned N              = 4,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned COMPUTE_CYCLES = 1
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        we_sel,
    output logic              acc_en,
    output logic              acc_clr,
    output logic              data_we,
    output logic [1:0]        jklm_select,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              next_row
`ifdef SEQ_STALL_COUNT_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    localparam int unsigned T  = N / 2;
    localparam int unsigned TW = (T > 1) ? $clog2(T) : 1;
    localparam int unsigned CW = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

    if ((N % 2 != 0) || (N < 2) || (COMPUTE_CYCLES < 1) || (ADDR_W > 32) ||
        (((3 * N * N - 1) >> ADDR_W) != 0)) begin : g_bad_params
        $error("matmul_tile_sequencer: illegal N / ADDR_W / COMPUTE_CYCLES");
    end

    state_e          state_q, state_d;
    logic [TW-1:0]   bi_q, bi_d, bj_q, bj_d, bk_q, bk_d;
    logic [2:0]      op_q, op_d;
    logic [1:0]      s_q, s_d;
    logic [CW-1:0]   cc_q, cc_d;
    logic            next_row_q, next_row_d;
    logic [ADDR_W-1:0] gen_rd_addr;
    logic [ADDR_W-1:0] gen_wr_addr;

    matmul_addr_gen #(
        .N      (N),
        .ADDR_W (ADDR_W),
        .TW     (TW)
    ) u_addr_gen (
        .bi      (bi_q),
        .bj      (bj_q),
        .bk      (bk_q),
        .op      (op_q),
        .s       (s_q),
        .rd_addr (gen_rd_addr),
        .wr_addr (gen_wr_addr)
    );

    always_comb begin
        state_d     = state_q;
        bi_d        = bi_q;
        bj_d        = bj_q;
        bk_d        = bk_q;
        op_d        = op_q;
        s_d         = s_q;
        cc_d        = cc_q;
        next_row_d  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        rd_addr     = '0;
        we_sel      = '0;
        acc_en      = 1'b0;
        acc_clr     = 1'b0;
        data_we     = 1'b0;
        jklm_select = SEL_J;
        wr_addr     = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    bi_d    = '0;
                    bj_d    = '0;
                    bk_d    = '0;
                    op_d    = OP_A;
                    s_d     = SEL_J;
                    cc_d    = '0;
                end
            end
            StLoad: begin
                busy    = 1'b1;
                rd_addr = gen_rd_addr;
                if (mem_ready) begin
                    we_sel = 8'b1 << op_q;
                    if (op_q == OP_H) begin
                        state_d = StCompute;
                        cc_d    = '0;
                    end else begin
                        op_d = op_q + 3'd1;
                    end
                end
            end
            StCompute: begin
                busy = 1'b1;
                if (cc_q == CW'(COMPUTE_CYCLES - 1)) begin
                    acc_en  = 1'b1;
                    acc_clr = (bk_q == '0);
                    if (bk_q != TW'(T - 1)) begin
                        bk_d    = bk_q + TW'(1);
                        op_d    = OP_A;
                        state_d = StLoad;
                    end else begin
                        s_d     = SEL_J;
                        state_d = StStore;
                    end
                end else begin
                    cc_d = cc_q + CW'(1);
                end
            end
            StStore: begin
                busy        = 1'b1;
                data_we     = 1'b1;
                jklm_select = s_q;
                wr_addr     = gen_wr_addr;
                if (s_q == SEL_M) begin
                    bk_d = '0;
                    op_d = OP_A;
                    if (bj_q != TW'(T - 1)) begin
                        bj_d    = bj_q + TW'(1);
                        state_d = StLoad;
                    end else if (bi_q != TW'(T - 1)) begin
                        // Row wrap: next_row is flagged on the first LOAD cycle of the new row
                        bj_d       = '0;
                        bi_d       = bi_q + TW'(1);
                        next_row_d = 1'b1;
                        state_d    = StLoad;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    s_d = s_q + 2'd1;
                end
            end
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q    <= StIdle;
            bi_q       <= '0;
            bj_q       <= '0;
            bk_q       <= '0;
            op_q       <= OP_A;
            s_q        <= SEL_J;
            cc_q       <= '0;
            next_row_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bi_q       <= bi_d;
            bj_q       <= bj_d;
            bk_q       <= bk_d;
            op_q       <= op_d;
            s_q        <= s_d;
            cc_q       <= cc_d;
            next_row_q <= next_row_d;
        end
    end

    assign next_row = next_row_q;

`ifdef SEQ_STALL_COUNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge Clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (state_q == StIdle && start) begin
            stall_q <= '0;
        end else if (state_q == StLoad && !mem_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Randomized self-checking bench: a nested-loop program model of the block walk
// predicts every output cycle for N=4/C=1 and N=2/C=3 instances.
module tb_matmul_tile_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, mem_ready, start4, start2;

    logic       busy4, done4, acc_en4, acc_clr4, data_we4, nr4;
    logic [7:0] rd4, we4, wr4;
    logic [1:0] sel4;
    logic       busy2, done2, acc_en2, acc_clr2, data_we2, nr2;
    logic [7:0] rd2, we2, wr2;
    logic [1:0] sel2;
`ifdef SEQ_STALL_COUNT_EN
    logic [15:0] stall4, stall2;
`endif

    matmul_tile_sequencer #(.N(4), .ADDR_W(8), .COMPUTE_CYCLES(1)) dut4 (
        .Clk (clk), .reset (reset), .start (start4), .mem_ready (mem_ready),
        .busy (busy4), .done (done4), .rd_addr (rd4), .we_sel (we4),
        .acc_en (acc_en4), .acc_clr (acc_clr4), .data_we (data_we4),
        .jklm_select (sel4), .wr_addr (wr4), .next_row (nr4)
`ifdef SEQ_STALL_COUNT_EN
        , .stall_count (stall4)
`endif
    );

    matmul_tile_sequencer #(.N(2), .ADDR_W(8), .COMPUTE_CYCLES(3)) dut2 (
        .Clk (clk), .reset (reset), .start (start2), .mem_ready (mem_ready),
        .busy (busy2), .done (done2), .rd_addr (rd2), .we_sel (we2),
        .acc_en (acc_en2), .acc_clr (acc_clr2), .data_we (data_we2),
        .jklm_select (sel2), .wr_addr (wr2), .next_row (nr2)
`ifdef SEQ_STALL_COUNT_EN
        , .stall_count (stall2)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic b, input logic d, input logic [7:0] rd,
                                         input logic [7:0] we, input logic ae, input logic ac,
                                         input logic dw, input logic [1:0] sel,
                                         input logic [7:0] wr, input logic nr);
        return {32'b0, b, d, rd, we, ae, ac, dw, sel, wr, nr};
    endfunction

    function automatic logic [63:0] observe(input int which);
        if (which == 0)
            return pack(busy4, done4, rd4, we4, acc_en4, acc_clr4, data_we4, sel4, wr4, nr4);
        return pack(busy2, done2, rd2, we2, acc_en2, acc_clr2, data_we2, sel2, wr2, nr2);
    endfunction

    // kind: 0 load, 1 compute wait, 2 compute accumulate, 3 store, 4 done
    typedef struct {
        int kind;
        int addr;
        int we;
        int clr;
        int sel;
        int nr;
    } act_t;

    act_t q[$];

    function automatic act_t mk(input int kind, input int addr, input int we, input int clr,
                                input int sel, input int nr);
        act_t a;
        a.kind = kind; a.addr = addr & 255; a.we = we; a.clr = clr; a.sel = sel; a.nr = nr;
        return a;
    endfunction

    task automatic build(input int n, input int c);
        int t;
        int r;
        int cl;
        t = n / 2;
        q.delete();
        for (int bi = 0; bi < t; bi++)
            for (int bj = 0; bj < t; bj++) begin
                for (int bk = 0; bk < t; bk++) begin
                    for (int op = 0; op < 8; op++) begin
                        r  = (op / 2) % 2;
                        cl = op % 2;
                        q.push_back(mk(0, (op < 4) ? ((2*bi + r) * n + 2*bk + cl)
                                                   : (n*n + (2*bk + r) * n + 2*bj + cl),
                                       1 << op, 0, 0,
                                       (bi > 0 && bj == 0 && bk == 0 && op == 0) ? 1 : 0));
                    end
                    for (int k = 0; k < c - 1; k++) q.push_back(mk(1, 0, 0, 0, 0, 0));
                    q.push_back(mk(2, 0, 0, (bk == 0) ? 1 : 0, 0, 0));
                end
                for (int s = 0; s < 4; s++)
                    q.push_back(mk(3, 2*n*n + (2*bi + s/2) * n + 2*bj + s%2, 0, 0, s, 0));
            end
        q.push_back(mk(4, 0, 0, 0, 0, 0));
    endtask

    // mode: 0 mem_ready high, 1 three-cycle stall on the op=2 load, 2 random mem_ready
    task automatic run_mult(input int which, input int n, input int c, input int mode,
                            input int ghost, input int rst_at, output int stalls);
        act_t a;
        logic [63:0] e;
        logic mr;
        int done_at;
        int loads;
        int t;
        build(n, c);
        stalls  = 0;
        loads   = 0;
        done_at = -1;
        @(posedge clk); #1;
        mem_ready = 1'b1;
        if (which == 0) start4 = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        check($sformatf("n%0d_idle_c0", n), observe(which), 64'd0);
        for (int cyc = 1; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            start4 = 1'b0;
            start2 = 1'b0;
            if (cyc == ghost) begin
                if (which == 0) start4 = 1'b1; else start2 = 1'b1;
            end
            reset = (cyc == rst_at);
            a = q[0];
            if (mode == 1)      mr = !(a.kind == 0 && loads == 2 && stalls < 3);
            else if (mode == 2) mr = ($urandom_range(0, 3) != 0);
            else                mr = 1'b1;
            mem_ready = mr;
            e = pack(1'b1, a.kind == 4, (a.kind == 0) ? 8'(a.addr) : 8'd0,
                     (a.kind == 0 && mr) ? 8'(a.we) : 8'd0, a.kind == 2,
                     a.kind == 2 && a.clr != 0, a.kind == 3,
                     (a.kind == 3) ? 2'(a.sel) : 2'd0, (a.kind == 3) ? 8'(a.addr) : 8'd0,
                     a.nr != 0);
            @(negedge clk);
            check($sformatf("n%0d_c%0d_cyc%0d", n, c, cyc), observe(which), e);
            q[0].nr = 0;
            if (a.kind == 0 && !mr) begin
                stalls++;
            end else begin
                if (a.kind == 0) loads++;
                void'(q.pop_front());
            end
            if (cyc == rst_at) break;
            if (a.kind == 4) begin
                done_at = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        reset     = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        check($sformatf("n%0d_after_end", n), observe(which), 64'd0);
        if (rst_at > 0) begin
            repeat (3) begin
                @(posedge clk); #1;
                @(negedge clk);
                check("reset_stays_idle", observe(which), 64'd0);
            end
        end else begin
            t = n / 2;
            check($sformatf("n%0d_done_cycle", n), 64'(done_at),
                  64'(t*t*(t*(8 + c) + 4) + 1 + stalls));
        end
    endtask

    int st;

    initial begin
        reset     = 1'b1;
        start4    = 1'b0;
        start2    = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset4", observe(0), 64'd0);
        check("reset2", observe(1), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_mult(0, 4, 1, 0, -1, -1, st);
        run_mult(0, 4, 1, 1, -1, -1, st);
`ifdef SEQ_STALL_COUNT_EN
        check("stall_count_directed", 64'(stall4), 64'd3);
`endif
        run_mult(0, 4, 1, 0, 30, -1, st);
        run_mult(0, 4, 1, 0, -1, 50, st);
        run_mult(0, 4, 1, 0, -1, -1, st);
        run_mult(1, 2, 3, 0, -1, -1, st);

        repeat (3) begin
            run_mult(0, 4, 1, 2, -1, -1, st);
`ifdef SEQ_STALL_COUNT_EN
            check("stall_count_rand4", 64'(stall4), 64'(st > 16'hFFFF ? 16'hFFFF : st));
`endif
            run_mult(1, 2, 3, 2, -1, -1, st);
`ifdef SEQ_STALL_COUNT_EN
            check("stall_count_rand2", 64'(stall2), 64'(st > 16'hFFFF ? 16'hFFFF : st));
`endif
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
